ldst_queue_n: RTL and testbench
===============================

LDST_QUEUE_N -- requirements
Module: ldst_queue_n

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DEPTH   8   queue entries; power of 2, minimum 2
  ADDR_W  32  address width
  DATA_W  32  data width
  CNTRL_W 16  core control-word width
  Z_W     4   core destination tag width
  ID_W    log2(DEPTH)  memory transaction ID width; derived, not overridable
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk          in   1        single clock; all state on rising edge
  rst          in   1        asynchronous, active-high reset
  memR         in   1        core load request
  memW         in   1        core store request
  addr_in_C    in   ADDR_W   request address
  data_in_C    in   DATA_W   store data
  cntrl_in_C   in   CNTRL_W  control word, carried to retire
  Z_in_C       in   Z_W      destination tag, carried to retire
  stall_out_C  out  1        queue full; core holds request
  empty        out  1        no valid entries
  addr_out_C   out  ADDR_W   retired load address
  data_out_C   out  DATA_W   retired load data
  cntrl_out_C  out  CNTRL_W  retired load control word
  Z_out_C      out  Z_W      retired load tag
  ready_out_C  out  1        one-cycle retired-load strobe
  addr_out_M   out  ADDR_W   memory request address
  data_out_M   out  DATA_W   memory store data
  rw_out_M     out  1        1 = write, 0 = read
  ldstID_out_M out  ID_W     request ID = entry index
  valid_out_M  out  1        memory request valid
  stall_in_M   in   1        memory cannot accept request this cycle
  data_in_M    in   DATA_W   load response data
  ldstID_in_M  in   ID_W     response ID
  ready_in_M   in   1        response valid (load data or store ack)

Function
REQ-003 Queue SHALL be circular, DEPTH entries; pointers head (retire), tail (allocate), iss (issue), each wrapping DEPTH-1 -> 0.
REQ-004 Entry states SHALL be FREE, WAIT (allocated, not issued), ISSUED, DONE.
REQ-005 Allocation: exactly one of memR/memW high and stall_out_C=0 -> entry[tail] written at the edge, tail+1; memR and memW both high -> no allocation.
REQ-006 stall_out_C SHALL be combinational, 1 iff all DEPTH entries are non-FREE; an entry freed in the same cycle does not lower stall_out_C until the next cycle.
REQ-007 Forwarding: an allocated load whose address equals that of a valid older store SHALL take the youngest such store's data, enter DONE directly, and never be issued to memory.
REQ-008 Non-forwarded loads and all stores SHALL enter WAIT.
REQ-009 Issue: valid_out_M SHALL be combinational, 1 iff entry[iss] is WAIT; the address, data, rw and ID fields SHALL be driven from entry[iss].
REQ-010 When valid_out_M=1 and stall_in_M=0, entry[iss] SHALL become ISSUED at the edge and iss SHALL advance to the next entry not forwarded, preserving program order to memory.
REQ-011 An entry allocated at edge N SHALL be issuable at the earliest in the cycle following edge N.
REQ-012 Response: ready_in_M=1 with entry[ldstID_in_M] ISSUED -> entry SHALL become DONE; loads capture data_in_M. A response to a non-ISSUED entry SHALL be ignored.
REQ-013 Responses may arrive out of order; retirement SHALL remain in order.
REQ-014 Retire: when entry[head] is DONE, the entry SHALL become FREE at the edge and head SHALL advance; for a load, the C-side outputs SHALL be registered and ready_out_C=1 for exactly the next cycle. A store SHALL retire silently.
REQ-015 At most one allocation, one issue, one response and one retire SHALL occur per cycle; all four may occur in the same cycle.
REQ-016 empty SHALL be 1 iff all entries are FREE.

Reset
REQ-017 rst=1 SHALL asynchronously free all entries, zero all pointers, drive ready_out_C and the C-side data outputs to 0 and empty to 1, and cancel in-flight requests; late responses are ignored per REQ-012.

Verification (DEPTH=4)
REQ-018 Store 0x28/9000, then load 0x28 -> load forwarded, no memory read, ready_out_C with data_out_C=9000.
REQ-019 Loads A (ID0) and B (ID1); responses ID1 then ID0 -> retire A then B, one ready_out_C pulse each.
REQ-020 4 stores with stall_in_M=1 -> stall_out_C=1, 5th request not allocated; after release and acks -> empty=1.
REQ-021 stall_in_M held 3 cycles -> valid_out_M held with stable address and ID; exactly one issue per request.
REQ-022 rst asserted with 2 entries ISSUED -> empty=1 immediately; responses that follow produce no ready_out_C.
REQ-023 Perform 10 alloc/retire pairs to wrap the pointers -> correct ID reuse 0..3 and in-order data.

Source files
------------

// File: rtl/ldst_queue_n.sv
// Purpose: in-order load/store queue between core and memory, with store-to-load forwarding.
// Latency: a request issues to memory no earlier than the cycle after allocation. ready_out_C pulses the cycle after a load retires.
// Backpressure: stall_out_C blocks allocation while every entry is occupied; stall_in_M holds the current memory request.
//
// Ports:
//   clk, rst                           clock and asynchronous active-high reset
//   memR/memW, *_in_C                  core request (exactly one of memR/memW allocates)
//   stall_out_C, empty                 queue full / queue idle
//   *_out_C, ready_out_C               retired-load result, registered, one-cycle strobe
//   *_out_M, valid_out_M, stall_in_M   memory request channel, driven from entry[iss]
//   data_in_M, ldstID_in_M, ready_in_M memory response (load data or store ack), any order
module ldst_queue_n #(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int CNTRL_W = 16,
   parameter int Z_W     = 4,
   localparam int ID_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               memR,
   input  logic               memW,
   input  logic [ADDR_W-1:0]  addr_in_C,
   input  logic [DATA_W-1:0]  data_in_C,
   input  logic [CNTRL_W-1:0] cntrl_in_C,
   input  logic [Z_W-1:0]     Z_in_C,
   output logic               stall_out_C,
   output logic               empty,
   output logic [ADDR_W-1:0]  addr_out_C,
   output logic [DATA_W-1:0]  data_out_C,
   output logic [CNTRL_W-1:0] cntrl_out_C,
   output logic [Z_W-1:0]     Z_out_C,
   output logic               ready_out_C,
   output logic [ADDR_W-1:0]  addr_out_M,
   output logic [DATA_W-1:0]  data_out_M,
   output logic               rw_out_M,
   output logic [ID_W-1:0]    ldstID_out_M,
   output logic               valid_out_M,
   input  logic               stall_in_M,
   input  logic [DATA_W-1:0]  data_in_M,
   input  logic [ID_W-1:0]    ldstID_in_M,
   input  logic               ready_in_M
);

   typedef enum logic [1:0] {FREE, WAIT, ISSUED, DONE} ent_state_t;

   localparam logic [ID_W-1:0] ONE = 1;

   // Entry lifecycle state; the only per-entry storage that needs reset.
   ent_state_t         st        [DEPTH];
   // Payload; meaningful only while the matching state is non-FREE.
   logic               is_st     [DEPTH];
   logic               fwd       [DEPTH];
   logic [ADDR_W-1:0]  ent_addr  [DEPTH];
   logic [DATA_W-1:0]  ent_data  [DEPTH];
   logic [CNTRL_W-1:0] ent_cntrl [DEPTH];
   logic [Z_W-1:0]     ent_z     [DEPTH];

   logic [ID_W-1:0]    head;
   logic [ID_W-1:0]    tail;
   logic [ID_W-1:0]    iss;

   logic               all_busy;
   logic               all_free;
   logic               alloc;
   logic               fwd_hit;
   logic [DATA_W-1:0]  fwd_dat;
   logic [ID_W-1:0]    fwd_idx;
   logic               issue;
   logic               skip;
   logic               rsp;
   logic               retire;

   always_comb begin
      all_busy = 1'b1;
      all_free = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if (st[i] == FREE) all_busy = 1'b0;
         else               all_free = 1'b0;
      end
   end

   assign stall_out_C = all_busy;
   assign empty       = all_free;

   assign alloc = (memR ^ memW) & ~all_busy;

   // Every occupied entry is older than the one being allocated at tail.
   // Walking from oldest to youngest lets the youngest matching store win.
   always_comb begin
      fwd_hit = 1'b0;
      fwd_dat = '0;
      fwd_idx = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         fwd_idx = tail - k[ID_W-1:0];
         if (st[fwd_idx] != FREE && is_st[fwd_idx] && ent_addr[fwd_idx] == addr_in_C) begin
            fwd_hit = 1'b1;
            fwd_dat = ent_data[fwd_idx];
         end
      end
   end

   assign valid_out_M  = (st[iss] == WAIT);
   assign addr_out_M   = ent_addr[iss];
   assign data_out_M   = ent_data[iss];
   assign rw_out_M     = is_st[iss];
   assign ldstID_out_M = iss;

   assign issue  = valid_out_M & ~stall_in_M;
   // A forwarded load never goes to memory, so the issue pointer steps over it
   // the first cycle it is visible (before it can retire and become FREE).
   assign skip   = (st[iss] == DONE) & fwd[iss];
   assign rsp    = ready_in_M & (st[ldstID_in_M] == ISSUED);
   assign retire = (st[head] == DONE);

   // Payload storage. Allocation (FREE entry) and response (ISSUED entry)
   // can never target the same index in one cycle.
   always_ff @(posedge clk) begin
      if (alloc) begin
         is_st[tail]     <= memW;
         fwd[tail]       <= memR & fwd_hit;
         ent_addr[tail]  <= addr_in_C;
         ent_data[tail]  <= memW ? data_in_C : fwd_dat;
         ent_cntrl[tail] <= cntrl_in_C;
         ent_z[tail]     <= Z_in_C;
      end
      if (rsp && !is_st[ldstID_in_M]) begin
         ent_data[ldstID_in_M] <= data_in_M;
      end
   end

   // Control: the four per-cycle operations touch distinct entries
   // (tail is FREE, iss is WAIT, response target is ISSUED, head is DONE).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) st[i] <= FREE;
         head        <= '0;
         tail        <= '0;
         iss         <= '0;
         ready_out_C <= 1'b0;
         addr_out_C  <= '0;
         data_out_C  <= '0;
         cntrl_out_C <= '0;
         Z_out_C     <= '0;
      end else begin
         if (alloc) begin
            st[tail] <= (memR & fwd_hit) ? DONE : WAIT;
            tail     <= tail + ONE;
         end
         if (issue) begin
            st[iss] <= ISSUED;
         end
         if (issue || skip) begin
            iss <= iss + ONE;
         end
         if (rsp) begin
            st[ldstID_in_M] <= DONE;
         end
         if (retire) begin
            st[head] <= FREE;
            head     <= head + ONE;
         end
         ready_out_C <= retire & ~is_st[head];
         if (retire && !is_st[head]) begin
            addr_out_C  <= ent_addr[head];
            data_out_C  <= ent_data[head];
            cntrl_out_C <= ent_cntrl[head];
            Z_out_C     <= ent_z[head];
         end
      end
   end

endmodule

// File: tb/tb_ldst_queue_n.sv
// Testbench for ldst_queue_n (DEPTH=4): directed scenarios with literal checks
// plus a per-cycle comparison against a program-order queue model.
module tb_ldst_queue_n;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        memR = 1'b0, memW = 1'b0;
   logic [31:0] addr_in_C = '0, data_in_C = '0;
   logic [15:0] cntrl_in_C = '0;
   logic [3:0]  Z_in_C = '0;
   logic        stall_out_C, empty;
   logic [31:0] addr_out_C, data_out_C;
   logic [15:0] cntrl_out_C;
   logic [3:0]  Z_out_C;
   logic        ready_out_C;
   logic [31:0] addr_out_M, data_out_M;
   logic        rw_out_M;
   logic [1:0]  ldstID_out_M;
   logic        valid_out_M;
   logic        stall_in_M = 1'b0;
   logic [31:0] data_in_M = '0;
   logic [1:0]  ldstID_in_M = '0;
   logic        ready_in_M = 1'b0;

   ldst_queue_n #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .CNTRL_W(16), .Z_W(4)) dut (
      .clk(clk), .rst(rst),
      .memR(memR), .memW(memW), .addr_in_C(addr_in_C), .data_in_C(data_in_C),
      .cntrl_in_C(cntrl_in_C), .Z_in_C(Z_in_C),
      .stall_out_C(stall_out_C), .empty(empty),
      .addr_out_C(addr_out_C), .data_out_C(data_out_C), .cntrl_out_C(cntrl_out_C),
      .Z_out_C(Z_out_C), .ready_out_C(ready_out_C),
      .addr_out_M(addr_out_M), .data_out_M(data_out_M), .rw_out_M(rw_out_M),
      .ldstID_out_M(ldstID_out_M), .valid_out_M(valid_out_M), .stall_in_M(stall_in_M),
      .data_in_M(data_in_M), .ldstID_in_M(ldstID_in_M), .ready_in_M(ready_in_M)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // ---------------- memory responder / observation logs ----------------
   typedef struct {
      logic [1:0]  id;
      logic [31:0] dat;
   } iss_t;

   iss_t        issued_log[$];
   logic [31:0] ret_log[$];
   logic [31:0] rmem [bit [31:0]];
   int          n_issues = 0;
   int          n_reads  = 0;

   // ---------------- program-order model ----------------
   // state: 0 = waiting for memory, 1 = at memory, 2 = complete
   typedef struct {
      bit          is_st;
      logic [31:0] addr;
      logic [31:0] data;
      logic [15:0] cntrl;
      logic [3:0]  z;
      int          id;
      int          state;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] amem [bit [31:0]];
   int          alloc_cnt = 0;
   bit          exp_rdy = 1'b0;
   logic [31:0] exp_a, exp_d;
   logic [15:0] exp_c;
   logic [3:0]  exp_z;

   always @(negedge clk) begin : model
      int    wi;
      bit    head_done, do_alloc, fwd;
      ment_t ne;
      iss_t  ie;
      if (rst) begin
         chk("rst_empty", empty, 1);
         chk("rst_stall", stall_out_C, 0);
         chk("rst_ready", ready_out_C, 0);
         chk("rst_dataC", data_out_C, 0);
         mq.delete();
         amem.delete();
         issued_log.delete();
         ret_log.delete();
         alloc_cnt = 0;
         exp_rdy   = 1'b0;
      end else begin
         chk("stall", stall_out_C, mq.size() == DEPTH);
         chk("empty", empty, mq.size() == 0);
         chk("ready", ready_out_C, exp_rdy);
         if (exp_rdy) begin
            chk("ret_addr",  addr_out_C,  exp_a);
            chk("ret_data",  data_out_C,  exp_d);
            chk("ret_cntrl", cntrl_out_C, exp_c);
            chk("ret_z",     Z_out_C,     exp_z);
         end
         wi = -1;
         foreach (mq[i]) if (wi < 0 && mq[i].state == 0) wi = i;
         if (valid_out_M) begin
            if (wi < 0) chk("spurious_issue", 1, 0);
            else begin
               chk("mem_addr", addr_out_M, mq[wi].addr);
               chk("mem_rw",   rw_out_M,   mq[wi].is_st);
               chk("mem_id",   ldstID_out_M, mq[wi].id);
               if (mq[wi].is_st) chk("mem_data", data_out_M, mq[wi].data);
            end
         end
         if (ready_out_C) ret_log.push_back(data_out_C);
         if (valid_out_M && !stall_in_M) begin
            n_issues++;
            ie.id = ldstID_out_M;
            if (rw_out_M) begin
               rmem[addr_out_M] = data_out_M;
               ie.dat = 32'h0;
            end else begin
               n_reads++;
               ie.dat = rmem.exists(addr_out_M) ? rmem[addr_out_M] : init_val(addr_out_M);
            end
            issued_log.push_back(ie);
         end
         // advance the model across the coming rising edge
         head_done = (mq.size() > 0) && (mq[0].state == 2);
         do_alloc  = (memR ^ memW) && (mq.size() < DEPTH);
         if (do_alloc) begin
            fwd = 1'b0;
            foreach (mq[i]) if (mq[i].is_st && mq[i].addr == addr_in_C) fwd = 1'b1;
            ne.is_st = memW;
            ne.addr  = addr_in_C;
            ne.cntrl = cntrl_in_C;
            ne.z     = Z_in_C;
            ne.id    = alloc_cnt % DEPTH;
            alloc_cnt++;
            if (memW) begin
               ne.data = data_in_C;
               ne.state = 0;
               amem[addr_in_C] = data_in_C;
            end else begin
               ne.data  = amem.exists(addr_in_C) ? amem[addr_in_C] : init_val(addr_in_C);
               ne.state = fwd ? 2 : 0;
            end
         end
         if (ready_in_M) foreach (mq[i]) if (mq[i].id == ldstID_in_M && mq[i].state == 1) mq[i].state = 2;
         if (valid_out_M && !stall_in_M && wi >= 0) mq[wi].state = 1;
         if (head_done) begin
            exp_rdy = !mq[0].is_st;
            exp_a = mq[0].addr;
            exp_d = mq[0].data;
            exp_c = mq[0].cntrl;
            exp_z = mq[0].z;
            void'(mq.pop_front());
         end else begin
            exp_rdy = 1'b0;
         end
         if (do_alloc) mq.push_back(ne);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit autor);
      iss_t e;
      @(posedge clk); #1;
      memR = r; memW = w; addr_in_C = a; data_in_C = d;
      cntrl_in_C = a[15:0]; Z_in_C = a[5:2];
      ready_in_M = 1'b0;
      if (autor && issued_log.size() > 0) begin
         e = issued_log.pop_front();
         ready_in_M = 1'b1; ldstID_in_M = e.id; data_in_M = e.dat;
      end
   endtask

   task automatic step_rsp(input logic [1:0] id, input logic [31:0] dat);
      @(posedge clk); #1;
      memR = 1'b0; memW = 1'b0;
      ready_in_M = 1'b1; ldstID_in_M = id; data_in_M = dat;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while ((mq.size() != 0 || issued_log.size() != 0) && t < 60) begin
         step(0, 0, 0, 0, 1);
         t++;
      end
      idle(2);
      chk(nm, t < 60, 1);
   endtask

   task automatic wait_issued(input int n, input string nm);
      int t = 0;
      while (issued_log.size() < n && t < 20) begin
         step(0, 0, 0, 0, 0);
         t++;
      end
      chk(nm, issued_log.size() >= n, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; memR = 0; memW = 0; ready_in_M = 0; stall_in_M = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rmem.delete();
      n_issues = 0;
      n_reads  = 0;
   endtask

   // ---------------- burst table ----------------
   typedef struct { bit r; bit w; logic [31:0] a; logic [31:0] d; } vec_t;
   vec_t burst[9];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  id0, id1;
      logic [31:0] d0, d1;

      do_reset();
      chk("reset_empty",  empty, 1);
      chk("reset_stall",  stall_out_C, 0);
      chk("reset_ready",  ready_out_C, 0);
      chk("reset_dataC",  data_out_C, 0);
      chk("reset_validM", valid_out_M, 0);

      // store 0x28/9000 then load 0x28: forwarded, never read from memory
      step(0, 1, 32'h28, 32'd9000, 0);
      step(1, 0, 32'h28, 32'h0, 0);
      drain("fwd_drain");
      chk("fwd_reads",   n_reads, 0);
      chk("fwd_issues",  n_issues, 1);
      chk("fwd_nret",    ret_log.size(), 1);
      if (ret_log.size() > 0) chk("fwd_data", ret_log[0], 32'd9000);
      chk("fwd_empty",   empty, 1);

      // two loads, responses out of order, retirement in order
      do_reset();
      step(1, 0, 32'h100, 0, 0);
      step(1, 0, 32'h104, 0, 0);
      wait_issued(2, "ooo_issued");
      if (issued_log.size() >= 2) begin
         chk("ooo_idA", issued_log[0].id, 0);
         chk("ooo_idB", issued_log[1].id, 1);
         step_rsp(issued_log[1].id, issued_log[1].dat);
         idle(3);
         chk("ooo_hold", ret_log.size(), 0);
         step_rsp(issued_log[0].id, issued_log[0].dat);
         idle(4);
      end
      chk("ooo_nret", ret_log.size(), 2);
      if (ret_log.size() >= 2) begin
         chk("ooo_retA", ret_log[0], 32'h5A5A_0100);
         chk("ooo_retB", ret_log[1], 32'h5A5A_0104);
      end
      issued_log.delete();
      chk("ooo_empty", empty, 1);

      // fill with stall_in_M held: full, 5th request dropped
      do_reset();
      stall_in_M = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 1, 32'h200 + 32'(4 * i), 32'hB0 + 32'(i), 0);
      idle(1);
      chk("full_stall", stall_out_C, 1);
      step(0, 1, 32'h210, 32'hBF, 0);
      idle(1);
      chk("full_stall2", stall_out_C, 1);
      chk("full_validM", valid_out_M, 1);
      chk("full_addrM",  addr_out_M, 32'h200);
      chk("full_idM",    ldstID_out_M, 0);
      stall_in_M = 1'b0;
      drain("full_drain");
      chk("full_empty",  empty, 1);
      chk("full_issues", n_issues, 4);

      // memory backpressure for 3 cycles: request held stable, issued once
      do_reset();
      stall_in_M = 1'b1;
      step(1, 0, 32'h300, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("hold_valid", valid_out_M, 1);
         chk("hold_addr",  addr_out_M, 32'h300);
         chk("hold_id",    ldstID_out_M, 0);
      end
      stall_in_M = 1'b0;
      drain("hold_drain");
      chk("hold_issues", n_issues, 1);
      chk("hold_nret",   ret_log.size(), 1);
      if (ret_log.size() > 0) chk("hold_data", ret_log[0], 32'h5A5A_0300);

      // reset with two loads in flight; late responses ignored
      do_reset();
      step(1, 0, 32'h400, 0, 0);
      step(1, 0, 32'h404, 0, 0);
      wait_issued(2, "rst_issued");
      id0 = 2'd0; id1 = 2'd1; d0 = 32'h1111; d1 = 32'h2222;
      if (issued_log.size() >= 2) begin
         id0 = issued_log[0].id; d0 = issued_log[0].dat;
         id1 = issued_log[1].id; d1 = issued_log[1].dat;
      end
      #2 rst = 1'b1;
      #1;
      chk("async_empty", empty, 1);
      chk("async_valid", valid_out_M, 0);
      @(posedge clk); #1 rst = 1'b0;
      step_rsp(id0, d0);
      step_rsp(id1, d1);
      idle(3);
      chk("late_noret", ret_log.size(), 0);
      chk("late_empty", empty, 1);

      // ten single-entry round trips wrap every pointer
      do_reset();
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) step(0, 1, 32'h500 + 32'(4 * (k / 2)), 32'hC000 + 32'(k), 0);
         else            step(1, 0, 32'h500 + 32'(4 * (k / 2)), 32'h0, 0);
         wait_issued(1, "wrap_issued");
         if (issued_log.size() > 0) chk("wrap_id", issued_log[0].id, 32'(k % 4));
         drain("wrap_drain");
         if (k % 2 == 1) begin
            chk("wrap_nret", ret_log.size(), 32'((k + 1) / 2));
            if (ret_log.size() > 0) chk("wrap_data", ret_log[ret_log.size() - 1], 32'hC000 + 32'(k - 1));
         end
      end

      // back-to-back mix with concurrent responses, checked by the model
      do_reset();
      burst[0] = '{0, 1, 32'h600, 32'hAAAA_0001};
      burst[1] = '{1, 0, 32'h600, 32'h0};
      burst[2] = '{0, 1, 32'h604, 32'hAAAA_0002};
      burst[3] = '{1, 0, 32'h608, 32'h0};
      burst[4] = '{0, 0, 32'h0,   32'h0};
      burst[5] = '{0, 1, 32'h600, 32'hAAAA_0003};
      burst[6] = '{1, 0, 32'h600, 32'h0};
      burst[7] = '{1, 0, 32'h604, 32'h0};
      burst[8] = '{1, 1, 32'h60C, 32'hDEAD};
      foreach (burst[i]) step(burst[i].r, burst[i].w, burst[i].a, burst[i].d, 1);
      drain("burst_drain");
      chk("burst_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
